// File: rtl/cfg_mgmt_responder.sv
// rtl/cfg_mgmt_responder.sv - cfg_mgmt target: fixed-latency DWORD register file responder
module cfg_mgmt_responder #(
  parameter int          REG_COUNT    = 64,
  parameter int          RESP_LATENCY = 4,
  parameter logic [15:0] VENDOR_ID    = 16'h10EE,
  parameter logic [15:0] DEVICE_ID    = 16'h9038,
  parameter int          FUNC_COUNT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic [15:0] access_count,
  output logic        proto_err
);

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int CW = $clog2(RESP_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      addr_q;
  logic [7:0]      func_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            is_wr_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     regs_q [0:REG_COUNT-1];

  logic            accept;
  logic            complete;
  logic            addr_ok;
  logic            func_ok;
  logic            wr_en;
  logic [AW-1:0]   idx;
  logic [31:0]     rd_val;

  assign addr_ok = ({1'b0, addr_q} < 11'(REG_COUNT));
  assign func_ok = ({1'b0, func_q} < 9'(FUNC_COUNT));
  assign idx     = addr_q[AW-1:0];
  assign wr_en   = complete & is_wr_q & func_ok & addr_ok & (addr_q != 10'd0);

  always_comb begin
    rd_val = 32'd0;
    if (!func_ok)
      rd_val = 32'hFFFF_FFFF;
    else if (!addr_ok)
      rd_val = 32'd0;
    else if (addr_q == 10'd0)
      rd_val = {DEVICE_ID, VENDOR_ID};
    else
      rd_val = regs_q[idx];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_mgmt_read | cfg_mgmt_write) begin
          accept  = 1'b1;
          cnt_d   = CW'(RESP_LATENCY - 2);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d  = complete;
    perr_d  = accept & cfg_mgmt_read & cfg_mgmt_write;
    count_d = complete ? count_q + 16'd1 : count_q;
    rdata_d = (complete & ~is_wr_q) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      count_q <= count_d;
      // Write wins when both strobes arrive together.
      if (accept) begin
        addr_q  <= cfg_mgmt_addr;
        func_q  <= cfg_mgmt_function_number;
        wdata_q <= cfg_mgmt_write_data;
        be_q    <= cfg_mgmt_byte_enable;
        is_wr_q <= cfg_mgmt_write;
      end
    end
  end

  // Entry 0 is the ID register and is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++)
        regs_q[r] <= '0;
    end else if (wr_en) begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (idx == AW'(r)) begin
          for (int b = 0; b < 4; b++)
            if (be_q[b])
              regs_q[r][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt_read_write_done = done_q;
  assign access_count             = count_q;
  assign proto_err                = perr_q;

endmodule

// File: tb/tb_cfg_mgmt_responder.sv
// tb/tb_cfg_mgmt_responder.sv - directed self-checking bench for cfg_mgmt_responder
module tb_cfg_mgmt_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = '0;
  logic [7:0]  func = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        rd = 1'b0;
  logic [31:0] read_data;
  logic        done;
  logic [15:0] access_count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  localparam logic [31:0] ID = 32'h9038_10EE;

  always #5 clk = ~clk;

  cfg_mgmt_responder dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .cfg_mgmt_addr            (addr),
    .cfg_mgmt_function_number (func),
    .cfg_mgmt_write           (wr),
    .cfg_mgmt_write_data      (wdata),
    .cfg_mgmt_byte_enable     (be),
    .cfg_mgmt_read            (rd),
    .cfg_mgmt_read_data       (read_data),
    .cfg_mgmt_read_write_done (done),
    .access_count             (access_count),
    .proto_err                (proto_err)
  );

  // Drives one request, holds it through the DONE edge, reports done cycle
  // (relative to accept edge A), number of done pulses and proto_err cycle.
  task automatic access(input logic r, input logic w, input logic [9:0] a,
                        input logic [7:0] f, input logic [31:0] d, input logic [3:0] b,
                        output int dc, output int nd, output int pc, output logic [31:0] rdat);
    @(negedge clk);
    rd = r; wr = w; addr = a; func = f; wdata = d; be = b;
    @(posedge clk);
    dc = -1; nd = 0; pc = -1; rdat = 'x;
    for (int k = 1; k <= 16 && dc < 0; k++) begin
      @(negedge clk);
      if (proto_err && pc < 0) pc = k;
      if (done) begin dc = k; nd++; rdat = read_data; end
    end
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  task automatic chk_access(input string name, input int dc, input int nd);
    checks++;
    if (dc !== 4 || nd !== 1) begin
      errors++;
      $display("FAIL %s timing: done_cycle=%0d pulses=%0d, required done_cycle=4 pulses=1", name, dc, nd);
    end
    checks++;
    if (access_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s access_count: got %h, required %h", name, access_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    int dc, nd, pc;
    logic [31:0] rv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (read_data !== 32'd0 || done !== 1'b0 || access_count !== 16'd0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rdata=%h done=%b cnt=%h perr=%b, required all zero", read_data, done, access_count, proto_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (read_data !== 32'd0 || done !== 1'b0 || access_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: rdata=%h done=%b cnt=%h, required all zero", read_data, done, access_count);
    end
    for (int a = 1; a < 64; a += 31) begin
      access(1'b1, 1'b0, 10'(a), 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
      exp_cnt++;
      chk_access("reset_read", dc, nd);
      checks++;
      if (rv !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %h, required 00000000", a, rv);
      end
    end
  endtask

  task automatic test_read_id();
    int dc, nd, pc;
    logic [31:0] rv;
    access(1'b1, 1'b0, 10'd0, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("read_id", dc, nd);
    checks++;
    if (rv !== ID) begin
      errors++;
      $display("FAIL read_id data: got %h, required %h", rv, ID);
    end
    checks++;
    if (pc !== -1) begin
      errors++;
      $display("FAIL read_id proto_err: pulsed in cycle %0d, required none", pc);
    end
  endtask

  task automatic test_byte_enables();
    int dc, nd, pc;
    logic [31:0] rv;
    access(1'b0, 1'b1, 10'd5, 8'd0, 32'hAABB_CCDD, 4'b0101, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("be_write", dc, nd);
    access(1'b1, 1'b0, 10'd5, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("be_read", dc, nd);
    checks++;
    if (rv !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL be_read data: got %h, required 00bb00dd", rv);
    end
    access(1'b0, 1'b1, 10'd0, 8'd0, 32'h1234_5678, 4'hF, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("ro_write", dc, nd);
    checks++;
    if (read_data !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL write_keeps_rdata: got %h, required 00bb00dd", read_data);
    end
    access(1'b1, 1'b0, 10'd0, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("ro_read", dc, nd);
    checks++;
    if (rv !== ID) begin
      errors++;
      $display("FAIL ro_read data: got %h, required %h", rv, ID);
    end
  endtask

  task automatic test_out_of_range();
    int dc, nd, pc;
    logic [31:0] rv;
    access(1'b1, 1'b0, 10'd100, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("oor_read", dc, nd);
    checks++;
    if (rv !== 32'd0) begin
      errors++;
      $display("FAIL oor_read data: got %h, required 00000000", rv);
    end
    access(1'b0, 1'b1, 10'd100, 8'd0, 32'hFFFF_FFFF, 4'hF, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("oor_write", dc, nd);
    access(1'b1, 1'b0, 10'd5, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("oor_check5", dc, nd);
    checks++;
    if (rv !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL oor_check5 data: got %h, required 00bb00dd", rv);
    end
    access(1'b1, 1'b0, 10'd5, 8'd1, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("bad_func", dc, nd);
    checks++;
    if (rv !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL bad_func data: got %h, required ffffffff", rv);
    end
    access(1'b0, 1'b1, 10'd5, 8'd1, 32'h0, 4'hF, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("bad_func_write", dc, nd);
    access(1'b1, 1'b0, 10'd5, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("bad_func_check5", dc, nd);
    checks++;
    if (rv !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL bad_func_check5 data: got %h, required 00bb00dd", rv);
    end
  endtask

  task automatic test_simultaneous();
    int dc, nd, pc;
    logic [31:0] rv;
    access(1'b1, 1'b1, 10'd7, 8'd0, 32'h1122_3344, 4'hF, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("simul", dc, nd);
    checks++;
    if (pc !== 1) begin
      errors++;
      $display("FAIL simul proto_err: pulsed in cycle %0d, required cycle 1", pc);
    end
    access(1'b1, 1'b0, 10'd7, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("simul_read", dc, nd);
    checks++;
    if (rv !== 32'h1122_3344) begin
      errors++;
      $display("FAIL simul_read data: got %h, required 11223344", rv);
    end
  endtask

  task automatic test_reset_mid();
    int dc, nd, pc, seen;
    logic [31:0] rv;
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; addr = 10'd9; func = 8'd0; wdata = 32'hDEAD_BEEF; be = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || access_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: done=%b cnt=%h, required 0/0000", done, access_count);
    end
    wr = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid done: saw %0d pulses, required 0", seen);
    end
    access(1'b1, 1'b0, 10'd9, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    exp_cnt++;
    chk_access("reset_mid_read", dc, nd);
    checks++;
    if (rv !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_read data: got %h, required 00000000", rv);
    end
  endtask

  task automatic test_wrap();
    int dc, nd, pc;
    logic [31:0] rv;
    // Preload the counter as if 65535 accesses had completed.
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    checks++;
    if (access_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h, required ffff", access_count);
    end
    exp_cnt = 16'h0000;
    access(1'b1, 1'b0, 10'd1, 8'd0, 32'd0, 4'd0, dc, nd, pc, rv);
    chk_access("wrap", dc, nd);
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_byte_enables();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
